// File: rtl/gamma_loader.sv
// Gamma LUT loader: owns the shared gamma bus, fills the LUT with an identity
// curve or a host-downloaded curve, and only enables correction on a complete curve.
module gamma_loader #(
  parameter int ENTRIES   = 768,
  parameter int AUTO_INIT = 1
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       init_req,
  input  logic       dl_active,
  input  logic       dl_wr,
  input  logic [7:0] dl_data,
  inout  wire [21:0] gamma_bus,
  output logic       busy,
  output logic       curve_valid,
  output logic       load_error
);

  typedef enum logic [1:0] {IDLE, INIT, LOAD} state_t;

  localparam state_t     RESET_STATE = (AUTO_INIT != 0) ? INIT : IDLE;
  localparam logic       RESET_BUSY  = (AUTO_INIT != 0);
  localparam logic [9:0] FULL        = 10'(ENTRIES);
  localparam logic [9:0] LAST        = 10'(ENTRIES - 1);

  state_t     state, state_n;
  logic [9:0] cnt, cnt_n, cnt_acc;
  logic [9:0] wr_addr, addr_n;
  logic [7:0] wr_value, value_n;
  logic       gamma_wr, wr_n;
  logic       gamma_en, en_n;
  logic       busy_n, cv_n, err_n;
  logic       ovf, ovf_n, ovf_acc;
  logic       dl_active_d, dl_rise, dl_fall;
  logic       present;

  // Bit 21 belongs to the consumer; it is a static strap, so no synchroniser.
  assign present          = gamma_bus[21];
  assign gamma_bus[20:0]  = {clk_sys, gamma_en, gamma_wr, wr_addr, wr_value};
  assign dl_rise          = dl_active & ~dl_active_d;
  assign dl_fall          = ~dl_active & dl_active_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RESET_STATE;
      cnt         <= '0;
      gamma_wr    <= 1'b0;
      wr_addr     <= '0;
      wr_value    <= '0;
      gamma_en    <= 1'b0;
      busy        <= RESET_BUSY;
      curve_valid <= 1'b0;
      load_error  <= 1'b0;
      ovf         <= 1'b0;
      dl_active_d <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      gamma_wr    <= wr_n;
      wr_addr     <= addr_n;
      wr_value    <= value_n;
      gamma_en    <= en_n;
      busy        <= busy_n;
      curve_valid <= cv_n;
      load_error  <= err_n;
      ovf         <= ovf_n;
      dl_active_d <= dl_active;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr_n    = 1'b0;
    addr_n  = wr_addr;
    value_n = wr_value;
    cv_n    = curve_valid;
    err_n   = load_error;
    ovf_n   = ovf;
    cnt_acc = cnt;
    ovf_acc = ovf;

    // A download start wins over anything else, including a running fill.
    if (dl_rise && state != LOAD) begin
      state_n = LOAD;
      cv_n    = 1'b0;
      err_n   = 1'b0;
      ovf_n   = 1'b0;
      cnt_n   = '0;
      if (dl_wr) begin
        wr_n    = 1'b1;
        addr_n  = '0;
        value_n = dl_data;
        cnt_n   = 10'd1;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (init_req) begin
            state_n = INIT;
            cnt_n   = '0;
            cv_n    = 1'b0;
          end
        end
        INIT: begin
          wr_n = 1'b1;
          if (init_req) begin
            addr_n  = '0;
            value_n = '0;
            cnt_n   = 10'd1;
          end else begin
            addr_n  = cnt;
            value_n = cnt[7:0];
            if (cnt == LAST) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 10'd1;
            end
          end
        end
        LOAD: begin
          if (dl_wr) begin
            if (cnt < FULL) begin
              wr_n    = 1'b1;
              addr_n  = cnt;
              value_n = dl_data;
              cnt_acc = cnt + 10'd1;
            end else begin
              ovf_acc = 1'b1;
            end
          end
          cnt_n = cnt_acc;
          ovf_n = ovf_acc;
          // The byte arriving with the fall is already folded into the length check.
          if (dl_fall) begin
            if (cnt_acc == FULL && !ovf_acc) begin
              cv_n    = 1'b1;
              state_n = IDLE;
            end else begin
              err_n   = 1'b1;
              state_n = INIT;
              cnt_n   = '0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n != IDLE) || (state == INIT);
    en_n   = (state_n == IDLE) && enable && curve_valid && present && !busy;
  end

endmodule

// File: tb/tb_gamma_loader.sv
// Self-checking bench for gamma_loader: a cycle-indexed table of expected bus
// writes is compared every cycle, plus directed checks on the status outputs.
module tb_gamma_loader;

  localparam int ENTRIES = 768;

  logic       clk_sys   = 1'b0;
  logic       reset_n   = 1'b0;
  logic       enable    = 1'b0;
  logic       init_req  = 1'b0;
  logic       dl_active = 1'b0;
  logic       dl_wr     = 1'b0;
  logic       present   = 1'b1;
  logic [7:0] dl_data   = 8'h00;
  wire [21:0] gamma_bus;
  logic       busy, curve_valid, load_error;

  int          cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          model_on = 1'b0;
  logic [17:0] exp_wr [int];

  assign gamma_bus[21] = present;

  gamma_loader #(.ENTRIES(ENTRIES), .AUTO_INIT(1)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .enable     (enable),
    .init_req   (init_req),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_data    (dl_data),
    .gamma_bus  (gamma_bus),
    .busy       (busy),
    .curve_valid(curve_valid),
    .load_error (load_error)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  function automatic logic [7:0] byte_of(input int kind, input int i);
    logic [31:0] v;
    v = i;
    if (kind == 0) return ~v[7:0];
    v = i * 7 + 3;
    return v[7:0];
  endfunction

  task automatic expect_fill(input int start, input int count);
    for (int i = 0; i < count; i++) exp_wr[start + i] = {10'(i), 8'(i)};
  endtask

  // Status right after a download start has been seen.
  task automatic probe(input int c0);
    if (cyc == c0 + 1) begin
      check_output("load_entry_busy", 32'(busy), 32'(1));
      check_output("load_entry_cv", 32'(curve_valid), 32'(0));
      check_output("load_entry_err", 32'(load_error), 32'(0));
      check_output("load_entry_en", 32'(gamma_bus[19]), 32'(0));
    end
  endtask

  // Raises dl_active now and streams n bytes; on return cyc == cf + 1 when do_fall.
  task automatic download(input int n, input int first_gap, input int kind, input bit fall_with_last,
                          input bit do_fall, output int cf, output logic [17:0] first_seen);
    int c0;
    c0 = cyc;
    cf = 0;
    first_seen = '0;
    dl_active = 1'b1;
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (i == 0) ? first_gap : (i * 5 + 1) % 4;
      repeat (gap) begin
        tick();
        probe(c0);
      end
      if (do_fall && fall_with_last && i == n - 1) begin
        dl_active = 1'b0;
        cf = cyc;
      end
      dl_wr   = 1'b1;
      dl_data = byte_of(kind, i);
      if (i < ENTRIES) exp_wr[cyc + 1] = {10'(i), byte_of(kind, i)};
      tick();
      probe(c0);
      if (i == 0) first_seen = gamma_bus[17:0];
      dl_wr = 1'b0;
    end
    if (do_fall && !fall_with_last) begin
      dl_active = 1'b0;
      cf = cyc;
      tick();
    end
  endtask

  initial begin
    int          c0, cf, ci, r;
    logic [17:0] first;

    fork
      forever begin
        @(negedge clk_sys);
        if (model_on) begin
          if (exp_wr.exists(cyc)) begin
            check_output("bus_write", 32'({gamma_bus[18], gamma_bus[17:0]}), 32'({1'b1, exp_wr[cyc]}));
            exp_wr.delete(cyc);
          end else begin
            check_output("bus_no_write", 32'(gamma_bus[18]), 32'(0));
          end
        end
      end
    join_none

    enable = 1'b1;
    tick();
    tick();
    check_output("reset_busy", 32'(busy), 32'(1));
    check_output("reset_cv", 32'(curve_valid), 32'(0));
    check_output("reset_err", 32'(load_error), 32'(0));
    check_output("reset_bus", 32'(gamma_bus[19:0]), 32'(0));
    check_output("clk_forward", 32'(gamma_bus[20]), 32'(1));

    // Identity fill after reset release
    reset_n = 1'b1;
    c0 = cyc;
    expect_fill(c0 + 1, ENTRIES);
    model_on = 1'b1;
    tick();
    check_output("fill_first", 32'(gamma_bus[18:0]), 32'({1'b1, 10'd0, 8'h00}));
    wait_until(c0 + 300);
    check_output("fill_299", 32'(gamma_bus[17:0]), 32'({10'd299, 8'h2B}));
    wait_until(c0 + 768);
    check_output("fill_last", 32'(gamma_bus[17:0]), 32'({10'd767, 8'hFF}));
    check_output("fill_last_busy", 32'(busy), 32'(1));
    tick();
    check_output("fill_done_busy", 32'(busy), 32'(0));
    check_output("fill_done_en", 32'(gamma_bus[19]), 32'(0));
    check_output("fill_done_cv", 32'(curve_valid), 32'(0));

    // Valid download, byte 0 together with the dl_active rise
    tick();
    download(768, 0, 0, 1'b0, 1'b1, cf, first);
    check_output("dl1_first", 32'(first), 32'({10'd0, 8'hFF}));
    check_output("dl1_cv", 32'(curve_valid), 32'(1));
    check_output("dl1_busy", 32'(busy), 32'(0));
    check_output("dl1_err", 32'(load_error), 32'(0));
    tick();
    check_output("dl1_en", 32'(gamma_bus[19]), 32'(1));

    // Short download, last byte arrives with the fall
    tick();
    download(500, 2, 0, 1'b1, 1'b1, cf, first);
    check_output("short_err", 32'(load_error), 32'(1));
    check_output("short_cv", 32'(curve_valid), 32'(0));
    check_output("short_en", 32'(gamma_bus[19]), 32'(0));
    expect_fill(cf + 2, ENTRIES);
    wait_until(cf + 769);
    check_output("short_fill_busy", 32'(busy), 32'(1));
    tick();
    check_output("short_done_busy", 32'(busy), 32'(0));
    check_output("short_sticky_err", 32'(load_error), 32'(1));
    check_output("short_done_en", 32'(gamma_bus[19]), 32'(0));

    // Overflow download: bytes past 767 must not reach the bus
    tick();
    download(800, 1, 0, 1'b0, 1'b1, cf, first);
    check_output("ovf_err", 32'(load_error), 32'(1));
    check_output("ovf_cv", 32'(curve_valid), 32'(0));
    expect_fill(cf + 2, ENTRIES);
    wait_until(cf + 770);
    check_output("ovf_done_busy", 32'(busy), 32'(0));

    // Download aborts a requested fill at write 300
    tick();
    init_req = 1'b1;
    ci = cyc;
    tick();
    init_req = 1'b0;
    check_output("init_busy", 32'(busy), 32'(1));
    expect_fill(ci + 2, 300);
    wait_until(ci + 301);
    download(768, 0, 1, 1'b0, 1'b1, cf, first);
    check_output("abort_first", 32'(first), 32'({10'd0, 8'h03}));
    check_output("abort_cv", 32'(curve_valid), 32'(1));
    tick();
    check_output("abort_en", 32'(gamma_bus[19]), 32'(1));

    // Consumer absent: writes continue, correction stays off
    present = 1'b0;
    tick();
    tick();
    check_output("absent_en_drop", 32'(gamma_bus[19]), 32'(0));
    download(768, 3, 0, 1'b0, 1'b1, cf, first);
    check_output("absent_cv", 32'(curve_valid), 32'(1));
    tick();
    tick();
    check_output("absent_en", 32'(gamma_bus[19]), 32'(0));
    present = 1'b1;
    tick();
    tick();
    check_output("present_en", 32'(gamma_bus[19]), 32'(1));

    // Asynchronous reset in the middle of a download
    tick();
    download(401, 0, 0, 1'b0, 1'b0, cf, first);
    check_output("pre_reset_wr", 32'(gamma_bus[18:8]), 32'({1'b1, 10'd400}));
    #2;
    model_on  = 1'b0;
    reset_n   = 1'b0;
    dl_active = 1'b0;
    #1;
    check_output("async_wr", 32'(gamma_bus[18]), 32'(0));
    check_output("async_cv", 32'(curve_valid), 32'(0));
    check_output("async_busy", 32'(busy), 32'(1));
    check_output("async_en", 32'(gamma_bus[19]), 32'(0));
    exp_wr.delete();
    tick();
    tick();
    reset_n = 1'b1;
    r = cyc;
    expect_fill(r + 1, ENTRIES);
    model_on = 1'b1;
    tick();
    check_output("refill_first", 32'(gamma_bus[18:0]), 32'({1'b1, 10'd0, 8'h00}));
    wait_until(r + 769);
    check_output("refill_done_busy", 32'(busy), 32'(0));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gamma_loader.md
Name: gamma_loader

Overview:
Control stage directly upstream of the gamma LUT stage; it is the only writer of the shared 22-bit gamma bus.
- Fills the 768-entry LUT (R 0..255, G 256..511, B 512..767) with an identity curve after reset or on request.
- Streams a host-downloaded 768-byte curve into the LUT.
- Gates gamma_en so correction is never applied to a partially written curve.

Parameters:
ENTRIES, 768, LUT depth and expected download length in bytes (3 x 256).
AUTO_INIT, 1, 1 = identity fill starts on reset release; 0 = idle until init_req.

Ports:
clk_sys  in  1  system clock; also forwarded on gamma_bus[20]
reset_n  in  1  asynchronous active-low reset
enable  in  1  user gamma enable (level)
init_req  in  1  one-cycle pulse: request identity refill
dl_active  in  1  high for the whole host download
dl_wr  in  1  one-cycle strobe: dl_data valid
dl_data  in  8  download byte; order R0..R255, G0..G255, B0..B255
gamma_bus  inout  22  [21] sampled (consumer present), [20] clk_sys, [19] gamma_en, [18] gamma_wr, [17:8] gamma_wr_addr, [7:0] gamma_value; bit 21 never driven
busy  out  1  fill or download in progress
curve_valid  out  1  LUT holds a complete host curve
load_error  out  1  last download was short or overflowed; sticky until next dl_active rise

Behaviour:
- One clock domain (clk_sys). Reset is asynchronous and active-low via reset_n; all registers are cleared asynchronously when reset_n is low.
- Reset values:
  - state = INIT if AUTO_INIT, else IDLE.
  - cnt = 0; gamma_wr = 0; gamma_wr_addr = 0; gamma_value = 0.
  - gamma_en = 0; curve_valid = 0; load_error = 0.
  - busy = 1 if AUTO_INIT, else 0.
- Bus drive: bits [20:0] are driven continuously; bit 20 = clk_sys combinationally; all other driven bits are registered.
- present = gamma_bus[21], used unsynchronised (static strap).
- cnt is 10 bits. dl_active is edge-detected against a one-cycle-delayed copy.
- States:
  - IDLE: busy = 0. dl_active rise -> LOAD. init_req -> INIT.
  - INIT: each cycle gamma_wr = 1, addr = cnt, value = cnt[7:0], cnt++.
    - After the write with cnt = ENTRIES-1: go to IDLE, cnt = 0.
    - A full fill is exactly 768 consecutive write cycles; busy falls the cycle after the last write.
    - INIT clears curve_valid on entry.
  - LOAD: on entry cnt = 0, curve_valid = 0, load_error = 0, busy = 1.
    - Each dl_wr with cnt < ENTRIES: next cycle gamma_wr = 1, addr = cnt, value = dl_data, cnt++. Write latency is exactly 1 cycle.
    - dl_wr with cnt = ENTRIES: no bus write; overflow flag set.
    - On dl_active fall:
      - if cnt == ENTRIES and no overflow: curve_valid = 1, go to IDLE.
      - otherwise: load_error = 1, go to INIT (identity restore).
- gamma_wr is a single-cycle pulse; it is 0 in IDLE and on LOAD cycles without an accepted dl_wr.
- gamma_en is registered: enable & curve_valid & present & ~busy. It is forced to 0 in the same cycle LOAD or INIT is entered.
- Simultaneous and boundary events:
  - dl_active rise during INIT: INIT is aborted and LOAD is entered; the download wins.
  - init_req during LOAD: ignored.
  - init_req during INIT: restarts at cnt = 0.
  - dl_wr in the same cycle as the dl_active rise: accepted as byte 0.
  - dl_wr while dl_active is low: ignored.
  - dl_wr in the same cycle as the dl_active fall: accepted and counted before the length check.
  - present = 0: writes still occur; gamma_en stays 0.
  - reset_n low mid-operation: everything returns to reset values immediately. The partial LUT contents are not trusted and curve_valid = 0.

Test Plan:
- AUTO_INIT = 1, release reset_n -> 768 consecutive gamma_wr pulses:
  - addr 0..767, value = addr & 8'hFF.
  - busy falls the cycle after addr 767; gamma_en stays 0 (curve_valid = 0).
- Download of 768 bytes with dl_data = ~i[7:0], gaps of 0-3 cycles, enable = 1, present = 1:
  - each write appears 1 cycle after its dl_wr at addr i.
  - after the dl_active fall: curve_valid = 1, gamma_en = 1 one cycle later.
- Short download of 500 bytes -> load_error = 1, curve_valid = 0, identity refill of 768 writes follows, gamma_en = 0.
- Overflow download of 800 bytes:
  - exactly 768 writes; bytes 768..799 are not written.
  - after the dl_active fall: load_error = 1, identity refill follows.
- dl_active rises at INIT write 300 -> INIT aborted; the next write is addr 0 with dl_data; a full 768-byte load then succeeds.
- Second scenario with present = 0 after a valid load -> gamma_en = 0.
- reset_n pulsed low mid-LOAD at byte 400 -> gamma_wr deasserts asynchronously; after release a new identity fill starts from addr 0.
